// File: rtl/coin_payment_controller.sv
// coin_payment_controller: coin credit keeper, purchase gate and paced change/refund dispenser
module coin_payment_controller #(
  parameter int MAX_CREDIT   = 15,
  parameter int DISPENSE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin,
  input  logic       insertCoin,
  input  logic       cancel,
  input  logic       activatemachine,
  input  logic [3:0] costo,
  input  logic       Done,
  output logic [3:0] money,
  output logic       start,
  output logic       coinOut,
  output logic       coinReject,
  output logic       lowFunds,
  output logic       busy
);
  localparam int CW = DISPENSE_GAP > 0 ? $clog2(DISPENSE_GAP + 1) : 1;
  localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, BREW = 3'd2, DISPENSE = 3'd3, REFUND = 3'd4;
  logic [2:0] state, state_n;
  logic [3:0] credit_n, v;
  logic [4:0] sum;
  logic [CW-1:0] cnt, cnt_n;
  logic prev_ins, coin_edge, fits, buy;
  logic start_n, out_n, rej_n, low_n, busy_n;
  assign coin_edge = insertCoin & ~prev_ins;
  assign v = coin ? 4'd5 : 4'd1;
  assign sum = {1'b0, money} + {1'b0, v};
  assign fits = sum <= 5'(MAX_CREDIT);
  assign buy = activatemachine && costo != 4'd0 && money >= costo;
  assign busy_n = state_n == BREW || state_n == DISPENSE || state_n == REFUND;
  always_comb begin
    state_n = state;
    credit_n = money;
    cnt_n = cnt;
    start_n = 1'b0;
    out_n = 1'b0;
    rej_n = 1'b0;
    low_n = 1'b0;
    case (state)
      IDLE: begin
        rej_n = coin_edge & ~fits;
        if (coin_edge && fits) begin
          credit_n = sum[3:0];
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_n = REFUND;
          rej_n = coin_edge;
          cnt_n = '0;
        end else if (buy) begin
          credit_n = money - costo;
          start_n = 1'b1;
          state_n = BREW;
          rej_n = coin_edge;
        end else begin
          low_n = activatemachine;
          rej_n = coin_edge & ~fits;
          credit_n = coin_edge && fits ? sum[3:0] : money;
        end
      end
      BREW: begin
        rej_n = coin_edge;
        cnt_n = '0;
        if (Done) state_n = money != 4'd0 ? DISPENSE : IDLE;
      end
      DISPENSE, REFUND: begin
        rej_n = coin_edge;
        if (cnt != '0) cnt_n = cnt - CW'(1);
        else if (money != 4'd0) begin
          out_n = 1'b1;
          credit_n = money - 4'd1;
          cnt_n = CW'(DISPENSE_GAP);
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      money <= '0;
      cnt <= '0;
      prev_ins <= 1'b0;
      start <= 1'b0;
      coinOut <= 1'b0;
      coinReject <= 1'b0;
      lowFunds <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      money <= credit_n;
      cnt <= cnt_n;
      prev_ins <= insertCoin;
      start <= start_n;
      coinOut <= out_n;
      coinReject <= rej_n;
      lowFunds <= low_n;
      busy <= busy_n;
    end
  end
endmodule
